// File: rtl/strong_brick_pkg.sv
// Shared types and helpers for the strong-brick playfield layer.
package strong_brick_pkg;

  localparam int MAT_ROWS       = 15;
  localparam int MAT_COLS       = 20;
  localparam int CELL_SHIFT_DEF = 5;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;

  typedef logic [0:MAT_ROWS-1][0:MAT_COLS-1] brick_mat_t;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    LOAD = ST_LOAD,
    RUN  = ST_RUN
  } brick_state_t;

  function automatic logic [4:0] row_popcount(input logic [0:MAT_COLS-1] r);
    logic [4:0] n;
    n = '0;
    for (int i = 0; i < MAT_COLS; i++) n = n + 5'(r[i]);
    return n;
  endfunction

endpackage

// File: rtl/strong_brick_pixel_lookup.sv
// Maps a VGA pixel to its playfield cell; indices are forced to 0 when off the grid.
module strong_brick_pixel_lookup
  import strong_brick_pkg::*;
#(
  parameter int CELL_SHIFT = CELL_SHIFT_DEF
) (
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  output logic [3:0]  row,
  output logic [4:0]  col,
  output logic        in_range
);

  logic [10:0] cell_x;
  logic [10:0] cell_y;

  always_comb begin
    cell_x   = pixelX >> CELL_SHIFT;
    cell_y   = pixelY >> CELL_SHIFT;
    in_range = (cell_y < 11'(MAT_ROWS)) && (cell_x < 11'(MAT_COLS));
    row      = in_range ? cell_y[3:0] : 4'd0;
    col      = in_range ? cell_x[4:0] : 5'd0;
  end

endmodule

// File: rtl/strong_brick_matrix.sv
// Live strong-brick playfield: loads a level map, serves hits and per-pixel draw queries.
// Define STRONG_BRICK_BREAK_EN to make bricks destructible; otherwise they never break.
module strong_brick_matrix
  import strong_brick_pkg::*;
#(
  parameter int HITS_TO_BREAK = 2,
  parameter int CELL_SHIFT    = CELL_SHIFT_DEF
) (
  input  logic        clk,
  input  logic        resetN,
  input  brick_mat_t  map0,
  input  brick_mat_t  map1,
  input  brick_mat_t  map2,
  input  brick_mat_t  map3,
  input  logic        load,
  input  logic [1:0]  level,
  input  logic [10:0] pixelX,
  input  logic [10:0] pixelY,
  input  logic        hit_valid,
  input  logic [3:0]  hit_row,
  input  logic [4:0]  hit_col,
  output logic        hit_ready,
  output logic        hit_ack,
  output logic        hit_solid,
  output logic        hit_destroyed,
  output logic        drawingRequest,
  output logic        busy,
  output logic [8:0]  bricks_left
);

  brick_state_t state;
  logic [3:0]   load_row;
  logic [1:0]   load_level;
  brick_mat_t   mat;
  brick_mat_t   sel_map;

  logic [3:0] pix_row;
  logic [4:0] pix_col;
  logic       pix_in_range;

  logic       hit_in_range;
  logic [3:0] hr;
  logic [4:0] hc;
  logic       hit_take;
  logic       hit_on_brick;
  logic       hit_breaks;

  always_comb begin
    case (load_level)
      2'd0:    sel_map = map0;
      2'd1:    sel_map = map1;
      2'd2:    sel_map = map2;
      default: sel_map = map3;
    endcase
  end

  strong_brick_pixel_lookup #(.CELL_SHIFT(CELL_SHIFT)) u_lookup (
    .pixelX   (pixelX),
    .pixelY   (pixelY),
    .row      (pix_row),
    .col      (pix_col),
    .in_range (pix_in_range)
  );

  // Out-of-grid hits use cell (0,0) as a harmless index and are masked by hit_in_range.
  assign hit_in_range = (hit_row < 4'(MAT_ROWS)) && (hit_col < 5'(MAT_COLS));
  assign hr           = hit_in_range ? hit_row : 4'd0;
  assign hc           = hit_in_range ? hit_col : 5'd0;
  assign busy         = (state == LOAD);
  assign hit_ready    = (state == RUN) && !load;
  assign hit_take     = hit_valid && hit_ready;
  assign hit_on_brick = hit_take && hit_in_range && mat[hr][hc];

`ifdef STRONG_BRICK_BREAK_EN
  logic [1:0] dmg [MAT_ROWS][MAT_COLS];
  logic [1:0] dmg_next;

  always_comb begin
    dmg_next   = (dmg[hr][hc] == 2'd3) ? 2'd3 : dmg[hr][hc] + 2'd1;
    hit_breaks = hit_on_brick && (dmg_next == 2'(HITS_TO_BREAK));
  end

  // Counters update on the transfer edge so a repeat hit next cycle sees the new value.
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int r = 0; r < MAT_ROWS; r++)
        for (int c = 0; c < MAT_COLS; c++)
          dmg[r][c] <= 2'd0;
    end else if (state == LOAD && !load) begin
      for (int c = 0; c < MAT_COLS; c++) dmg[load_row][c] <= 2'd0;
    end else if (hit_on_brick) begin
      dmg[hr][hc] <= dmg_next;
    end
  end
`else
  assign hit_breaks = 1'b0;
`endif

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      state          <= IDLE;
      load_row       <= 4'd0;
      load_level     <= 2'd0;
      mat            <= '0;
      bricks_left    <= 9'd0;
      hit_ack        <= 1'b0;
      hit_solid      <= 1'b0;
      hit_destroyed  <= 1'b0;
      drawingRequest <= 1'b0;
    end else begin
      hit_ack        <= hit_take;
      hit_solid      <= hit_on_brick;
      hit_destroyed  <= hit_breaks;
      drawingRequest <= (state == RUN) && pix_in_range && mat[pix_row][pix_col];
      if (load) begin
        state       <= LOAD;
        load_row    <= 4'd0;
        load_level  <= level;
        bricks_left <= 9'd0;
      end else if (state == LOAD) begin
        mat[load_row] <= sel_map[load_row];
        bricks_left   <= bricks_left + 9'(row_popcount(sel_map[load_row]));
        if (load_row == 4'(MAT_ROWS - 1)) state <= RUN;
        else load_row <= load_row + 4'd1;
      end else if (hit_breaks) begin
        mat[hr][hc] <= 1'b0;
        bricks_left <= bricks_left - 9'd1;
      end
    end
  end

endmodule

// File: tb/tb_strong_brick_matrix.sv
// Directed self-checking bench for strong_brick_matrix (expectations follow STRONG_BRICK_BREAK_EN).
module tb_strong_brick_matrix;
  import strong_brick_pkg::*;

`ifdef STRONG_BRICK_BREAK_EN
  localparam bit BRK = 1'b1;
`else
  localparam bit BRK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        resetN;
  brick_mat_t  m0, m1, m2, m3;
  logic        load;
  logic [1:0]  level;
  logic [10:0] pixelX, pixelY;
  logic        hit_valid;
  logic [3:0]  hit_row;
  logic [4:0]  hit_col;
  logic        hit_ready, hit_ack, hit_solid, hit_destroyed, drawingRequest, busy;
  logic [8:0]  bricks_left;

  int compared   = 0;
  int mismatched = 0;
  int cyc;

  always #5 clk = ~clk;

  strong_brick_matrix #(.HITS_TO_BREAK(2), .CELL_SHIFT(5)) dut (
    .clk            (clk),
    .resetN         (resetN),
    .map0           (m0),
    .map1           (m1),
    .map2           (m2),
    .map3           (m3),
    .load           (load),
    .level          (level),
    .pixelX         (pixelX),
    .pixelY         (pixelY),
    .hit_valid      (hit_valid),
    .hit_row        (hit_row),
    .hit_col        (hit_col),
    .hit_ready      (hit_ready),
    .hit_ack        (hit_ack),
    .hit_solid      (hit_solid),
    .hit_destroyed  (hit_destroyed),
    .drawingRequest (drawingRequest),
    .busy           (busy),
    .bricks_left    (bricks_left)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic [1:0] lv);
    load  = 1'b1;
    level = lv;
    tick();
    load  = 1'b0;
  endtask

  task automatic waitLoad(output int cycles);
    cycles = 0;
    while (busy === 1'b1 && cycles < 100) begin
      cycles++;
      tick();
    end
  endtask

  task automatic hitCell(input logic [3:0] r, input logic [4:0] c);
    hit_valid = 1'b1;
    hit_row   = r;
    hit_col   = c;
    tick();
  endtask

  initial begin
    // Level 0: 11 bricks, row 4 cols 10..16 and row 7 cols 2..5.
    m0 = '0; m1 = '0; m2 = '0; m3 = '0;
    for (int c = 10; c <= 16; c++) m0[4][c] = 1'b1;
    for (int c = 2; c <= 5; c++) m0[7][c] = 1'b1;
    for (int c = 0; c < 20; c++) begin m1[0][c] = 1'b1; m1[14][c] = 1'b1; end
    for (int c = 0; c < 12; c++) m2[5][c] = 1'b1;
    for (int r = 0; r < 15; r++) m3[r][0] = 1'b1;
    for (int c = 1; c <= 9; c++) m3[9][c] = 1'b1;

    resetN = 1'b0; load = 1'b0; level = 2'd0;
    pixelX = 11'd0; pixelY = 11'd0;
    hit_valid = 1'b0; hit_row = 4'd0; hit_col = 5'd0;
    #12;
    checkOutput("reset_busy", 16'(busy), 16'd0);
    checkOutput("reset_ready", 16'(hit_ready), 16'd0);
    checkOutput("reset_left", 16'(bricks_left), 16'd0);
    checkOutput("reset_draw", 16'(drawingRequest), 16'd0);
    checkOutput("reset_ack", 16'(hit_ack), 16'd0);
    resetN = 1'b1;
    tick();

    applyStimulus(2'd0);
    waitLoad(cyc);
    checkOutput("l0_busy_cycles", 16'(cyc), 16'd15);
    checkOutput("l0_left", 16'(bricks_left), 16'd11);
    checkOutput("l0_ready", 16'(hit_ready), 16'd1);
    pixelX = 11'd416; pixelY = 11'd128;
    tick();
    checkOutput("l0_draw_416_128", 16'(drawingRequest), 16'd1);
    pixelX = 11'd0; pixelY = 11'd0;
    tick();
    checkOutput("l0_draw_0_0", 16'(drawingRequest), 16'd0);

    // Five back-to-back hits on (4,13); a break needs two.
    for (int i = 0; i < 5; i++) begin
      hitCell(4'd4, 5'd13);
      checkOutput($sformatf("hit413_ack%0d", i), 16'(hit_ack), 16'd1);
      checkOutput($sformatf("hit413_solid%0d", i), 16'(hit_solid), BRK ? 16'(i < 2) : 16'd1);
      checkOutput($sformatf("hit413_destr%0d", i), 16'(hit_destroyed), 16'(BRK && i == 1));
    end
    checkOutput("hit413_left", 16'(bricks_left), BRK ? 16'd10 : 16'd11);
    pixelX = 11'd416; pixelY = 11'd128;
    hitCell(4'd0, 5'd0);
    checkOutput("hit00_ack", 16'(hit_ack), 16'd1);
    checkOutput("hit00_solid", 16'(hit_solid), 16'd0);
    checkOutput("draw_after_hits", 16'(drawingRequest), BRK ? 16'd0 : 16'd1);
    hitCell(4'd15, 5'd3);
    checkOutput("hit15_3_ack", 16'(hit_ack), 16'd1);
    checkOutput("hit15_3_solid", 16'(hit_solid), 16'd0);
    checkOutput("hit15_3_destr", 16'(hit_destroyed), 16'd0);
    checkOutput("hit15_3_left", 16'(bricks_left), BRK ? 16'd10 : 16'd11);
    hit_valid = 1'b0;
    tick();
    checkOutput("ack_pulse_end", 16'(hit_ack), 16'd0);

    applyStimulus(2'd1);
    waitLoad(cyc);
    checkOutput("l1_left", 16'(bricks_left), 16'd40);
    pixelX = 11'd639; pixelY = 11'd479;
    tick();
    checkOutput("l1_draw_corner", 16'(drawingRequest), 16'd1);
    pixelX = 11'd640; pixelY = 11'd0;
    tick();
    checkOutput("l1_draw_col20", 16'(drawingRequest), 16'd0);

    applyStimulus(2'd3);
    waitLoad(cyc);
    checkOutput("l3_left", 16'(bricks_left), 16'd24);

    // Hit held through a level-2 load is stalled until the first RUN cycle.
    applyStimulus(2'd2);
    hit_valid = 1'b1; hit_row = 4'd5; hit_col = 5'd0;
    #1;
    cyc = 0;
    while (busy === 1'b1 && cyc < 100) begin
      checkOutput("load_ready_low", 16'(hit_ready), 16'd0);
      checkOutput("load_no_ack", 16'(hit_ack), 16'd0);
      cyc++;
      tick();
    end
    checkOutput("l2_busy_cycles", 16'(cyc), 16'd15);
    checkOutput("l2_left", 16'(bricks_left), 16'd12);
    checkOutput("run_ready", 16'(hit_ready), 16'd1);
    tick();
    hit_valid = 1'b0;
    checkOutput("run_first_ack", 16'(hit_ack), 16'd1);
    checkOutput("run_first_solid", 16'(hit_solid), 16'd1);

    // Reload interrupted at LOAD cycle 5 by a level-3 request.
    applyStimulus(2'd1);
    repeat (5) tick();
    applyStimulus(2'd3);
    waitLoad(cyc);
    checkOutput("restart_cycles", 16'(cyc), 16'd15);
    checkOutput("restart_left", 16'(bricks_left), 16'd24);

    // Asynchronous reset in the middle of a load (row 7).
    applyStimulus(2'd0);
    repeat (7) tick();
    resetN = 1'b0;
    #2;
    checkOutput("midreset_busy", 16'(busy), 16'd0);
    checkOutput("midreset_left", 16'(bricks_left), 16'd0);
    checkOutput("midreset_draw", 16'(drawingRequest), 16'd0);
    resetN = 1'b1;
    tick();
    checkOutput("midreset_idle", 16'(busy), 16'd0);
    checkOutput("midreset_ready", 16'(hit_ready), 16'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/strong_brick_matrix.md
Name: strong_brick_matrix

Overview:
Live strong-brick playfield store, directly downstream of the strong-brick map ROM, which supplies four constant 15x20 maps (mat_out0..3).
- On a level load, copies the selected map into a local register matrix.
- Tracks hit damage per cell and removes a brick when it breaks.
- Answers per-pixel draw queries for the VGA mux.
- Serves bullet-collision hit requests through a valid/ready handshake.

Parameters:
HITS_TO_BREAK, 2, hits needed to destroy one strong brick (1..3).
CELL_SHIFT, 5, log2 of cell size in pixels (32x32 cells cover 640x480).

Ports:
clk  in  1  system clock
resetN  in  1  asynchronous active-low reset
map0  in  [0:14][0:19]  strong-brick map, level 0
map1  in  [0:14][0:19]  strong-brick map, level 1
map2  in  [0:14][0:19]  strong-brick map, level 2
map3  in  [0:14][0:19]  strong-brick map, level 3
load  in  1  one-cycle pulse; start copying the map selected by level
level  in  2  map select, sampled only in the cycle load=1
pixelX  in  11  current VGA pixel X
pixelY  in  11  current VGA pixel Y
hit_valid  in  1  hit request valid
hit_row  in  4  hit cell row (0..14)
hit_col  in  5  hit cell column (0..19)
hit_ready  out  1  block can accept a hit this cycle
hit_ack  out  1  one-cycle pulse, hit processed
hit_solid  out  1  qualified by hit_ack: cell held a brick
hit_destroyed  out  1  qualified by hit_ack: this hit removed the brick
drawingRequest  out  1  current pixel lies on a live brick
busy  out  1  load in progress
bricks_left  out  9  count of live bricks

Behaviour:
- Reset: matrix cleared; damage counters = 0; state = IDLE; all outputs = 0.
- States:
  - IDLE: go to LOAD on load.
  - LOAD: copies row r in LOAD cycle r (r = 0..14); damage counters of row r cleared; bricks_left accumulates the row popcount (cleared to 0 on entry). Go to RUN after row 14 (15 cycles).
  - RUN: go to LOAD on load.
- load during LOAD restarts at row 0 with the newly sampled level.
- busy = 1 in LOAD. hit_ready = 1 only in RUN with load = 0.
- Hit transfer occurs when hit_valid && hit_ready. hit_ack and flags are registered, appearing 1 cycle after the transfer.
  - hit_solid = matrix bit.
  - If solid: damage counter increments. When it reaches HITS_TO_BREAK, the cell is cleared, hit_destroyed = 1, bricks_left decrements in the same cycle as hit_ack.
  - Out-of-range row/col (row > 14 or col > 19): ack with solid = 0, destroyed = 0, no state change.
- Back-to-back hits are accepted every cycle. A hit on the same cell in the next cycle sees the updated counter (no stale read).
- Draw query: col = pixelX >> CELL_SHIFT, row = pixelY >> CELL_SHIFT.
  - drawingRequest = registered matrix[row][col], 1-cycle latency.
  - Forced 0 if row > 14, col > 19, or state != RUN.
- A cell cleared by a hit stops drawing from the cycle after hit_ack.
- Damage counter width: 2 bits; saturates, never wraps.

Optional Feature:
STRONG_BRICK_BREAK_EN:
- Defined: the damage and destruction behaviour above applies.
- Undefined: strong bricks are indestructible. Hits are still acked with correct hit_solid, hit_destroyed stays 0, bricks_left is constant after load, and damage counters are not synthesized.

Decomposition:
- Package strong_brick_pkg:
  - MAT_ROWS = 15, MAT_COLS = 20, CELL_SHIFT_DEF = 5.
  - typedef brick_mat_t = logic [0:14][0:19].
  - typedef brick_state_t enum {IDLE, LOAD, RUN}.
- One natural sub-module: strong_brick_pixel_lookup, the combinational pixel-to-cell index plus range check, reused by other playfield layers.

Test Plan:
- Reset low mid-LOAD (row 7) -> next cycle busy = 0, bricks_left = 0, drawingRequest = 0; state IDLE.
- load, level = 0 -> busy high for exactly 15 cycles, bricks_left = 11. Pixel (416,128) gives drawingRequest = 1 one cycle later; pixel (0,0) gives 0.
- level 1 load -> bricks_left = 40; level 2 -> 12; level 3 -> 24. load re-pulsed at LOAD cycle 5 with level = 3 -> final count 24.
- BREAK_EN, HITS_TO_BREAK = 2, map 0:
  - Hit (4,13) -> ack, solid = 1, destroyed = 0.
  - Hit (4,13) again next cycle -> destroyed = 1, bricks_left = 10, pixel (416,128) draws 0.
  - Hit (0,0) -> solid = 0.
  - Hit (15,3) -> ack, no change.
- Without BREAK_EN: 5 hits on (4,13) -> all solid = 1, destroyed = 0, bricks_left stays 11.
- hit_valid asserted during LOAD -> hit_ready = 0 and no ack until RUN. The request is then accepted on the first RUN cycle.
